sram_rr_arbiter: RTL and testbench
==================================

# sram_rr_arbiter

Two-requester round-robin arbiter and access sequencer for the single-port, synchronous-read 16x8 SRAM. It accepts at most one read or write per cycle from either client, registers the winning command onto the SRAM port and routes the read data back to the issuing client with a valid pulse. It sits between the two memory clients and the SRAM and is the only driver of the SRAM control inputs.

## Interface
- ADDR_W, 4, SRAM address width.
- DATA_W, 8, SRAM word width.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  access request; held with its command until granted.
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  DATA_W  write data (ignored for reads).
- lock0 / lock1  in  1  keep ownership after this access; present only with SRAM_ARB_LOCK_EN.
- gnt0 / gnt1  out  1  combinational; high = command accepted at this rising edge.
- rvalid0 / rvalid1  out  1  registered one-cycle pulse; rdata holds this client's read result.
- rdata  out  DATA_W  shared read-data bus, equal to sram_data_out.
- sram_write_en, sram_read_en  out  1  registered SRAM strobes.
- sram_address  out  ADDR_W  registered SRAM address.
- sram_data_in  out  DATA_W  registered SRAM write data.
- sram_data_out  in  DATA_W  SRAM registered read data.

## Operation
- Grant: with one req high, grant it. With both high, grant the client not granted last (last_gnt register). At most one gnt per cycle. No req means no gnt. gnt is forced to 0 while reset is high.
- On the accepting edge:
  - the winner's command is registered onto sram_* (read: sram_read_en=1, sram_write_en=0; write: the opposite);
  - a stage-1 tag {valid, id} is stored;
  - last_gnt is updated.
- An idle cycle registers both strobes low. Address and data hold their last value.
- Read return: the stage-1 tag moves to the stage-2 tag at the next edge, when the SRAM captures the read. rvalid[id] is high for the following cycle. Writes produce no rvalid.
- Ordering: commands reach the SRAM in acceptance order. A write accepted at edge E followed by a read of the same address at E+1 returns the new data.
- Fairness: a client that keeps req high is granted within 2 cycles.
- Reset, including mid-operation: all strobes, sram_address, sram_data_in, both tags, rvalid0/1 and last_gnt (=1, so client 0 wins the first tie) go to 0/1 as stated. In-flight reads are dropped and return no rvalid.

## Timing
- Throughput: one access per cycle, back-to-back, either client.
- Write: accepted at E0, SRAM updated at E1.
- Read: accepted at E0, SRAM reads at E1, rvalid/rdata valid in the cycle after E1. Latency is 2 cycles.
- A client must hold req/we/addr/wdata stable until the cycle where its gnt is high. It may present a new command in the next cycle.

## Configuration
- SRAM_ARB_LOCK_EN defined:
  - lock0/lock1 ports exist, plus a 3-state owner FSM (IDLE, OWN0, OWN1).
  - IDLE -> OWNi when client i is granted with lock_i=1.
  - In OWNi only client i can be granted. OWNi -> IDLE when client i is granted with lock_i=0, or when req_i is low for a cycle (deadlock release).
  - Reset -> IDLE.
- Undefined: no lock ports and no FSM. Pure round-robin.

## Structure
- Shared package: ADDR_W/DATA_W defaults, client id encoding (CLIENT0=0, CLIENT1=1) and owner-state encoding.
- One sub-module, rr_pick2: combinational two-way round-robin pick from req vector and last_gnt, with an optional mask for lock ownership. The command and tag pipeline stays in the top.

## Test plan
- Reset mid-read: read accepted, reset at E1 -> no rvalid, all outputs 0, next tie grants client 0.
- Single client: client 0 writes 0xA5 to addr 3, then reads addr 3 -> gnt0 in consecutive cycles, rvalid0 two cycles after the read grant, rdata=0xA5, rvalid1 stays 0.
- Contention: both clients read continuously (client 0 addr 1 = 0x11, client 1 addr 2 = 0x22) -> grants alternate 0,1,0,1, rvalids alternate with the correct data, one access per cycle.
- Write-then-read hazard: client 1 writes 0x5C to addr 7, client 0 reads addr 7 in the next cycle -> rvalid0 with rdata=0x5C.
- Lock (macro on): client 1 does 3 accesses with lock1=1, then one with lock1=0, while client 0 requests throughout -> gnt0 only after client 1's unlocked access. Client 1 dropping req while locked releases ownership in the next cycle.
- Idle: no requests for 5 cycles -> sram_read_en = sram_write_en = 0, no rvalid.

Source files
------------

// File: rtl/sram_rr_arbiter_pkg.sv
// Shared definitions for the two-client SRAM round-robin arbiter: default widths,
// client id encoding and lock-owner state encoding.
package sram_rr_arbiter_pkg;

    localparam int unsigned DefAddrW = 4;
    localparam int unsigned DefDataW = 8;

    typedef enum logic {
        Client0 = 1'b0,
        Client1 = 1'b1
    } client_e;

    typedef enum logic [1:0] {
        OwnIdle = 2'd0,
        Own0    = 2'd1,
        Own1    = 2'd2
    } owner_e;

endpackage

// File: rtl/sram_rr_arbiter_pick2.sv
// Combinational two-way round-robin pick: ties go to the client not granted last;
// mask_i removes clients that may not be granted this cycle.
module rr_pick2
    import sram_rr_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o
);

    logic [1:0] eligible;

    always_comb begin
        eligible = req_i & mask_i;
        gnt_o    = eligible;
        if (eligible == 2'b11) begin
            gnt_o = (last_gnt_i == Client1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Two-client round-robin arbiter and access sequencer for a 16x8 synchronous-read SRAM.
// Optional ownership locking is built when SRAM_ARB_LOCK_EN is defined.
module sram_rr_arbiter
    import sram_rr_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              reset,
`ifdef SRAM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              sram_write_en,
    output logic              sram_read_en,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_data_in,
    input  logic [DATA_W-1:0] sram_data_out
);

    logic [1:0]        req, mask, pick, gnt;
    logic              accept, we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    logic              last_gnt_q;
    logic              write_en_q, read_en_q;
    logic [ADDR_W-1:0] address_q;
    logic [DATA_W-1:0] data_in_q;
    logic              s1_valid_q, s1_id_q;
    logic [1:0]        rvalid_q;

    assign req = {req1, req0};

    rr_pick2 u_pick (
        .req_i      (req),
        .mask_i     (mask),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (pick)
    );

    assign gnt  = reset ? 2'b00 : pick;
    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

`ifdef SRAM_ARB_LOCK_EN
    owner_e owner_q, owner_d;

    // Owner drops back to idle on an unlocked access or when its request lapses.
    always_comb begin
        owner_d = owner_q;
        mask    = 2'b11;
        case (owner_q)
            OwnIdle: begin
                if (gnt[0] && lock0) begin
                    owner_d = Own0;
                end else if (gnt[1] && lock1) begin
                    owner_d = Own1;
                end
            end
            Own0: begin
                mask = 2'b01;
                if ((gnt[0] && !lock0) || !req0) begin
                    owner_d = OwnIdle;
                end
            end
            Own1: begin
                mask = 2'b10;
                if ((gnt[1] && !lock1) || !req1) begin
                    owner_d = OwnIdle;
                end
            end
            default: owner_d = OwnIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OwnIdle;
        end else begin
            owner_q <= owner_d;
        end
    end
`else
    assign mask = 2'b11;
`endif

    assign accept    = |gnt;
    assign we_sel    = gnt[1] ? we1 : we0;
    assign addr_sel  = gnt[1] ? addr1 : addr0;
    assign wdata_sel = gnt[1] ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q <= Client1;
            write_en_q <= 1'b0;
            read_en_q  <= 1'b0;
            address_q  <= '0;
            data_in_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= Client0;
            rvalid_q   <= 2'b00;
        end else begin
            write_en_q <= accept && we_sel;
            read_en_q  <= accept && !we_sel;
            if (accept) begin
                address_q  <= addr_sel;
                data_in_q  <= wdata_sel;
                last_gnt_q <= gnt[1];
            end
            // Only reads carry a tag; the second stage is the one-hot rvalid itself.
            s1_valid_q <= accept && !we_sel;
            s1_id_q    <= gnt[1];
            rvalid_q   <= {s1_valid_q && (s1_id_q == Client1),
                           s1_valid_q && (s1_id_q == Client0)};
        end
    end

    assign sram_write_en = write_en_q;
    assign sram_read_en  = read_en_q;
    assign sram_address  = address_q;
    assign sram_data_in  = data_in_q;
    assign rvalid0       = rvalid_q[0];
    assign rvalid1       = rvalid_q[1];
    assign rdata         = sram_data_out;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter with a behavioural 16x8 synchronous-read SRAM;
// lock steps are compiled in when SRAM_ARB_LOCK_EN is defined.
module tb_sram_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic       lock0 = 1'b0, lock1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       sram_write_en, sram_read_en;
    logic [3:0] sram_address;
    logic [7:0] sram_data_in, sram_data_out;
    logic [7:0] mem [16];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sram_rr_arbiter dut (
        .clk           (clk),
        .reset         (reset),
`ifdef SRAM_ARB_LOCK_EN
        .lock0         (lock0),
        .lock1         (lock1),
`endif
        .req0          (req0),
        .req1          (req1),
        .we0           (we0),
        .we1           (we1),
        .addr0         (addr0),
        .addr1         (addr1),
        .wdata0        (wdata0),
        .wdata1        (wdata1),
        .gnt0          (gnt0),
        .gnt1          (gnt1),
        .rvalid0       (rvalid0),
        .rvalid1       (rvalid1),
        .rdata         (rdata),
        .sram_write_en (sram_write_en),
        .sram_read_en  (sram_read_en),
        .sram_address  (sram_address),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out)
    );

    always_ff @(posedge clk) begin
        if (sram_write_en) mem[sram_address] <= sram_data_in;
        if (sram_read_en) sram_data_out <= mem[sram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: gnt forced low even with a pending request
        #1 reset = 1'b1;
        req0 = 1'b1;
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_rd_en", sram_read_en, 0);
        chk("rst_wr_en", sram_write_en, 0);
        chk("rst_addr", sram_address, 0);
        chk("rst_rvalid", {rvalid1, rvalid0}, 0);
        req0 = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Single client: write 0xA5 to addr 3, then read it back
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 8'hA5;
        @(negedge clk);
        chk("a_gnt_wr", {gnt1, gnt0}, 2'b01);
        tick();
        chk("a_wr_en", sram_write_en, 1);
        chk("a_wr_addr", sram_address, 3);
        chk("a_wr_data", sram_data_in, 8'hA5);
        we0 = 1'b0;
        @(negedge clk);
        chk("a_gnt_rd", {gnt1, gnt0}, 2'b01);
        tick();
        req0 = 1'b0;
        chk("a_rd_en", {sram_write_en, sram_read_en}, 2'b01);
        @(negedge clk);
        chk("a_no_gnt", {gnt1, gnt0}, 2'b00);
        chk("a_rvalid_early", {rvalid1, rvalid0}, 2'b00);
        tick();
        chk("a_rvalid", {rvalid1, rvalid0}, 2'b01);
        chk("a_rdata", rdata, 8'hA5);
        chk("a_idle_rd_en", sram_read_en, 0);
        tick();
        chk("a_rvalid_pulse", {rvalid1, rvalid0}, 2'b00);

        // Write-then-read hazard: client 1 writes 0x5C to 7, client 0 reads 7 next
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd7; wdata1 = 8'h5C;
        @(negedge clk);
        chk("b_gnt_wr", {gnt1, gnt0}, 2'b10);
        tick();
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd7;
        @(negedge clk);
        chk("b_gnt_rd", {gnt1, gnt0}, 2'b01);
        tick();
        req0 = 1'b0;
        tick();
        chk("b_rvalid", {rvalid1, rvalid0}, 2'b01);
        chk("b_rdata", rdata, 8'h5C);

        // Contention: preload 0x11@1 (client 0) and 0x22@2 (client 1), then both read
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 8'h11;
        tick();
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 4'd2; wdata1 = 8'h22;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            @(negedge clk);
            if (k < 4) begin
                chk("c_gnt", {gnt1, gnt0}, (k % 2 == 0) ? 2'b01 : 2'b10);
            end else begin
                chk("c_gnt_off", {gnt1, gnt0}, 2'b00);
            end
            chk("c_rd_en", sram_read_en, (k >= 1 && k <= 4) ? 1 : 0);
            if (k >= 2) begin
                chk("c_rvalid", {rvalid1, rvalid0}, (k % 2 == 0) ? 2'b01 : 2'b10);
                chk("c_rdata", rdata, (k % 2 == 0) ? 8'h11 : 8'h22);
            end
            tick();
        end

        // Idle: five cycles with no requests
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("d_strobes", {sram_write_en, sram_read_en}, 2'b00);
            chk("d_rvalid", {rvalid1, rvalid0}, 2'b00);
            tick();
        end

        // Reset mid-read: client 0 read accepted, reset before the SRAM read edge
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd3;
        @(negedge clk);
        chk("e_gnt", {gnt1, gnt0}, 2'b01);
        tick();
        req0 = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("e_rst_rd_en", sram_read_en, 0);
        chk("e_rst_addr", sram_address, 0);
        chk("e_rst_data", sram_data_in, 0);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("e_no_rvalid", {rvalid1, rvalid0}, 2'b00);
            tick();
        end
        req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        @(negedge clk);
        chk("e_tie_after_rst", {gnt1, gnt0}, 2'b01);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

`ifdef SRAM_ARB_LOCK_EN
        // Lock: client 1 holds ownership for three locked accesses plus one unlocked
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2; lock1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("f_locked_gnt", {gnt1, gnt0}, 2'b10);
            tick();
        end
        lock1 = 1'b0;
        @(negedge clk);
        chk("f_unlock_gnt", {gnt1, gnt0}, 2'b10);
        tick();
        @(negedge clk);
        chk("f_after_unlock", {gnt1, gnt0}, 2'b01);
        tick();
        req0 = 1'b0; lock1 = 1'b1;
        @(negedge clk);
        chk("f_relock_gnt", {gnt1, gnt0}, 2'b10);
        tick();
        req1 = 1'b0; lock1 = 1'b0; req0 = 1'b1;
        @(negedge clk);
        chk("f_masked", {gnt1, gnt0}, 2'b00);
        tick();
        @(negedge clk);
        chk("f_released", {gnt1, gnt0}, 2'b01);
        tick();
        req0 = 1'b0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
